// File: rtl/script_runner.sv
// Kitchen-script sequencer: walks ScriptMem via pc, decodes each 16-bit word and issues
// operate/target command bytes toward the UART send path, stalling on feedback or time.
module script_runner #(
    parameter int unsigned TICK_CYCLES = 9600,
    parameter int unsigned PC_W        = 8
) (
    input  logic            uart_clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic            script_mode,
    input  logic [15:0]     script,
    input  logic [3:0]      feedback,
    input  logic            cmd_ready,
    output logic [PC_W-1:0] pc,
    output logic [7:0]      cmd_bits,
    output logic            cmd_valid,
    output logic            running,
    output logic            done,
    output logic            error
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StIssue,
        StWaitFb,
        StWaitT,
        StDone,
        StError
    } state_e;

    localparam logic [2:0] OpNop    = 3'b000;
    localparam logic [2:0] OpAct    = 3'b001;
    localparam logic [2:0] OpTgt    = 3'b010;
    localparam logic [2:0] OpWaitFb = 3'b011;
    localparam logic [2:0] OpJmp    = 3'b100;
    localparam logic [2:0] OpWaitT  = 3'b101;
    localparam logic [2:0] OpEnd    = 3'b111;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      cmd_q, cmd_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic [1:0]      fb_idx_q, fb_idx_d;
    logic            fb_level_q, fb_level_d;
    logic [31:0]     cnt_q, cnt_d;

    logic [2:0]      op;
    logic [7:0]      arg;
    logic [PC_W-1:0] pc_inc;
    logic            fb_match;
    logic            script_unused;

    assign op            = script[2:0];
    assign arg           = script[15:8];
    assign script_unused = ^script[7:3];
    assign pc_inc        = pc_q + PC_W'(1);
    assign fb_match      = (feedback[fb_idx_q] == fb_level_q);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cmd_d       = cmd_q;
        cmd_valid_d = cmd_valid_q;
        fb_idx_d    = fb_idx_q;
        fb_level_d  = fb_level_q;
        cnt_d       = cnt_q;

        if (script_mode) begin
            // Loading a new script always wins, even over a frozen run.
            state_d     = StIdle;
            pc_d        = '0;
            cmd_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (enable) state_d = StFetch;
                end
                StFetch: begin
                    if (enable) state_d = StDecode;
                end
                StDecode: begin
                    if (enable) begin
                        case (op)
                            OpNop: begin
                                pc_d    = pc_inc;
                                state_d = StFetch;
                            end
                            OpAct: begin
                                if (arg >= 8'd1 && arg <= 8'd5) begin
                                    cmd_d       = {arg[5:0], 2'b10};
                                    cmd_valid_d = 1'b1;
                                    state_d     = StIssue;
                                end else begin
                                    state_d = StError;
                                end
                            end
                            OpTgt: begin
                                if (arg >= 8'd1 && arg <= 8'd20) begin
                                    cmd_d       = {arg[5:0], 2'b11};
                                    cmd_valid_d = 1'b1;
                                    state_d     = StIssue;
                                end else begin
                                    state_d = StError;
                                end
                            end
                            OpWaitFb: begin
                                fb_idx_d   = arg[1:0];
                                fb_level_d = arg[4];
                                state_d    = StWaitFb;
                            end
                            OpJmp: begin
                                pc_d    = PC_W'(arg);
                                state_d = StFetch;
                            end
                            OpWaitT: begin
                                if (arg == 8'd0) begin
                                    pc_d    = pc_inc;
                                    state_d = StFetch;
                                end else begin
                                    cnt_d   = 32'(arg) * TICK_CYCLES;
                                    state_d = StWaitT;
                                end
                            end
                            OpEnd:   state_d = StDone;
                            default: state_d = StError;
                        endcase
                    end
                end
                StIssue: begin
                    // Handshake uses the gated valid so a ready seen while frozen is ignored.
                    if (cmd_valid && cmd_ready) begin
                        cmd_valid_d = 1'b0;
                        pc_d        = pc_inc;
                        state_d     = StFetch;
                    end
                end
                StWaitFb: begin
                    if (enable && fb_match) begin
                        pc_d    = pc_inc;
                        state_d = StFetch;
                    end
                end
                StWaitT: begin
                    if (enable) begin
                        if (cnt_q <= 32'd1) begin
                            cnt_d   = '0;
                            pc_d    = pc_inc;
                            state_d = StFetch;
                        end else begin
                            cnt_d = cnt_q - 32'd1;
                        end
                    end
                end
                StDone:  state_d = StDone;
                StError: state_d = StError;
            endcase
        end
    end

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pc_q        <= '0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            fb_idx_q    <= '0;
            fb_level_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            fb_idx_q    <= fb_idx_d;
            fb_level_q  <= fb_level_d;
            cnt_q       <= cnt_d;
        end
    end

    assign pc        = pc_q;
    assign cmd_bits  = cmd_q;
    assign cmd_valid = cmd_valid_q & enable;
    assign running   = (state_q != StIdle) && (state_q != StDone) && (state_q != StError);
    assign done      = (state_q == StDone);
    assign error     = (state_q == StError);

endmodule
